// File: rtl/budget_bench_pkg.sv
// Shared types and width helpers for the multi-channel budget bench.
// The optional budget refill is enabled by defining BUDGET_REFILL_EN.
package budget_bench_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_WAIT = 2'd1,
        CH_FAIL = 2'd2
    } ch_state_t;

    // The wait counter must be able to hold the value DEADLINE itself.
    function automatic int wait_w(input int deadline);
        return (deadline < 1) ? 1 : $clog2(deadline + 1);
    endfunction

    function automatic int refill_w(input int period);
        return (period <= 1) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/budget_bench_ch.sv
// One request channel: IDLE/WAIT/FAIL state, deadline wait counter and
// saturating response budget. The arbiter's decision arrives on i_resp.
module budget_bench_ch
    import budget_bench_pkg::*;
#(
    parameter int CNT_W    = 3,
    parameter int LIMIT    = 3,
    parameter int DEADLINE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_ctrl,
    input  logic i_resp,
    input  logic i_refill,
    output logic o_elig,
    output logic o_fail_nxt
);

    localparam int WAIT_W = wait_w(DEADLINE);

    ch_state_t          r_state, w_state_nxt;
    logic [WAIT_W-1:0]  r_wait, w_wait_nxt, w_wait_inc;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_eff;
    logic               w_req;

    // A pending request persists in CH_WAIT; a fresh i_req there is the same request.
    assign w_req      = i_req | (r_state == CH_WAIT);
    // Refill lands before the response is counted, so eligibility sees the cleared budget.
    assign w_cnt_eff  = (i_refill && (r_state != CH_FAIL)) ? '0 : r_cnt;
    assign w_wait_inc = r_wait + 1'b1;
    assign o_elig     = w_req & i_ctrl & (w_cnt_eff < CNT_W'(LIMIT)) & (r_state != CH_FAIL);
    assign o_fail_nxt = (w_state_nxt == CH_FAIL);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_cnt_nxt   = w_cnt_eff;
        if (r_state != CH_FAIL) begin
            if (i_resp) begin
                w_cnt_nxt   = w_cnt_eff + 1'b1;
                w_wait_nxt  = '0;
                w_state_nxt = CH_IDLE;
            end else if (w_req) begin
                w_wait_nxt  = w_wait_inc;
                w_state_nxt = (w_wait_inc == WAIT_W'(DEADLINE)) ? CH_FAIL : CH_WAIT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, reset asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CH_IDLE;
            r_wait  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/budget_bench.sv
// Multi-channel request/response bench: fixed-priority arbiter, sticky errors,
// optional periodic budget refill (define BUDGET_REFILL_EN).
module budget_bench
    import budget_bench_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int CNT_W         = 3,
    parameter int LIMIT         = 3,
    parameter int DEADLINE      = 1,
    parameter int REFILL_PERIOD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] i,
    input  logic [N_CH-1:0] controllable_i,
    output logic            error,
    output logic [N_CH-1:0] err_ch,
    output logic [N_CH-1:0] grant,
    output logic            _rt_get
);

    logic [N_CH-1:0] w_elig, w_resp, w_fail_nxt;
    logic [N_CH-1:0] r_grant, r_err_ch;
    logic            r_error;
    logic            w_refill;

`ifdef BUDGET_REFILL_EN
    localparam int REFILL_W = refill_w(REFILL_PERIOD);
    logic [REFILL_W-1:0] r_refill_cnt;

    assign w_refill = (r_refill_cnt == REFILL_W'(REFILL_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_refill_cnt <= '0;
        else if (w_refill) r_refill_cnt <= '0;
        else               r_refill_cnt <= r_refill_cnt + 1'b1;
    end
`else
    logic w_unused_refill;
    assign w_unused_refill = ^REFILL_PERIOD;
    assign w_refill        = 1'b0;
`endif

    // Isolate the lowest set eligibility bit: lowest channel index wins.
    assign w_resp = w_elig & (~w_elig + 1'b1);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        budget_bench_ch #(
            .CNT_W    (CNT_W),
            .LIMIT    (LIMIT),
            .DEADLINE (DEADLINE)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_req      (i[k]),
            .i_ctrl     (controllable_i[k]),
            .i_resp     (w_resp[k]),
            .i_refill   (w_refill),
            .o_elig     (w_elig[k]),
            .o_fail_nxt (w_fail_nxt[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_err_ch <= '0;
            r_error  <= 1'b0;
        end else begin
            r_grant  <= w_resp;
            r_err_ch <= w_fail_nxt;
            r_error  <= |w_fail_nxt;
        end
    end

    assign grant   = r_grant;
    assign err_ch  = r_err_ch;
    assign error   = r_error;
    assign _rt_get = |i;

endmodule

// File: tb/tb_budget_bench.sv
// Directed self-checking bench for budget_bench; four instances differ in DEADLINE.
// Refill expectations follow BUDGET_REFILL_EN.
module tb_budget_bench;

    logic clk;
    logic rst_n;

    logic [1:0] i_d1, c_d1, err_ch_d1, grant_d1;
    logic [1:0] i_d2, c_d2, err_ch_d2, grant_d2;
    logic [1:0] i_d3, c_d3, err_ch_d3, grant_d3;
    logic [1:0] i_d16, c_d16, err_ch_d16, grant_d16;
    logic       error_d1, error_d2, error_d3, error_d16;
    logic       rt_d1, rt_d2, rt_d3, rt_d16;

    int n_checks = 0;
    int n_errors = 0;

    budget_bench #(.DEADLINE(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .i(i_d1), .controllable_i(c_d1),
        .error(error_d1), .err_ch(err_ch_d1), .grant(grant_d1), ._rt_get(rt_d1)
    );
    budget_bench #(.DEADLINE(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .i(i_d2), .controllable_i(c_d2),
        .error(error_d2), .err_ch(err_ch_d2), .grant(grant_d2), ._rt_get(rt_d2)
    );
    budget_bench #(.DEADLINE(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .i(i_d3), .controllable_i(c_d3),
        .error(error_d3), .err_ch(err_ch_d3), .grant(grant_d3), ._rt_get(rt_d3)
    );
    budget_bench #(.DEADLINE(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .i(i_d16), .controllable_i(c_d16),
        .error(error_d16), .err_ch(err_ch_d16), .grant(grant_d16), ._rt_get(rt_d16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {i_d1, c_d1, i_d2, c_d2, i_d3, c_d3, i_d16, c_d16} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic       exp_e;

        // Reset values
        rst_n = 1'b0;
        {i_d1, c_d1, i_d2, c_d2, i_d3, c_d3, i_d16, c_d16} = '0;
        #1;
        check("rst_grant", grant_d1, 2'b00);
        check("rst_err_ch", err_ch_d1, 2'b00);
        check("rst_error", error_d1, 1'b0);
        check("rst_rt_get", rt_d1, 1'b0);
        do_reset();

        // Budget exhaustion without refill, DEADLINE=1
        i_d1 = 2'b01; c_d1 = 2'b01;
        #1;
        check("rt_get_comb", rt_d1, 1'b1);
        for (int e = 1; e <= 3; e++) begin
            tick();
            check($sformatf("exh_grant_e%0d", e), grant_d1, 2'b01);
            check($sformatf("exh_err_e%0d", e), error_d1, 1'b0);
        end
        tick();
        check("exh_grant_e4", grant_d1, 2'b00);
        check("exh_err_ch_e4", err_ch_d1, 2'b01);
        check("exh_error_e4", error_d1, 1'b1);
        do_reset();

        // Contention: DEADLINE=1 and DEADLINE=2 side by side
        i_d1 = 2'b11; c_d1 = 2'b11;
        i_d2 = 2'b11; c_d2 = 2'b11;
        tick();
        check("cont1_grant", grant_d1, 2'b01);
        check("cont1_err_ch", err_ch_d1, 2'b10);
        check("cont1_error", error_d1, 1'b1);
        check("cont2_grant_e1", grant_d2, 2'b01);
        check("cont2_err_e1", error_d2, 1'b0);
        i_d1 = 2'b00; i_d2 = 2'b00;
        tick();
        check("cont1_err_ch_sticky", err_ch_d1, 2'b10);
        check("cont2_grant_e2", grant_d2, 2'b10);
        check("cont2_err_e2", error_d2, 1'b0);
        tick();
        check("cont2_grant_e3", grant_d2, 2'b00);
        check("cont2_err_e3", error_d2, 1'b0);
        do_reset();

        // Denied grant, DEADLINE=3: request held in CH_WAIT after i drops
        i_d3 = 2'b01; c_d3 = 2'b00;
        tick();
        check("deny_err_ch_e1", err_ch_d3, 2'b00);
        i_d3 = 2'b00;
        tick();
        check("deny_err_ch_e2", err_ch_d3, 2'b00);
        tick();
        check("deny_err_ch_e3", err_ch_d3, 2'b01);
        check("deny_error_e3", error_d3, 1'b1);
        tick();
        check("deny_err_ch_e4", err_ch_d3, 2'b01);
        check("deny_grant_e4", grant_d3, 2'b00);
        do_reset();

        // Asynchronous reset from CH_FAIL with a grant outstanding
        i_d1 = 2'b11; c_d1 = 2'b11;
        tick();
        check("arst_pre_grant", grant_d1, 2'b01);
        check("arst_pre_err_ch", err_ch_d1, 2'b10);
        i_d1 = 2'b00; c_d1 = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", grant_d1, 2'b00);
        check("arst_err_ch", err_ch_d1, 2'b00);
        check("arst_error", error_d1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        i_d1 = 2'b01; c_d1 = 2'b01;
        tick();
        check("arst_post_grant", grant_d1, 2'b01);
        check("arst_post_error", error_d1, 1'b0);
        do_reset();

        // Refill window, DEADLINE=16: refill strobe on edge 16 after reset
        i_d16 = 2'b01; c_d16 = 2'b01;
        for (int e = 1; e <= 19; e++) begin
            tick();
            exp_g = (e <= 3) ? 2'b01 : 2'b00;
            exp_e = 1'b0;
`ifdef BUDGET_REFILL_EN
            if (e >= 16 && e <= 18) exp_g = 2'b01;
`else
            if (e == 19) exp_e = 1'b1;
`endif
            check($sformatf("refill_grant_e%0d", e), grant_d16, exp_g);
            check($sformatf("refill_error_e%0d", e), error_d16, exp_e);
        end
`ifdef BUDGET_REFILL_EN
        check("refill_err_ch_e19", err_ch_d16, 2'b00);
`else
        check("refill_err_ch_e19", err_ch_d16, 2'b01);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/budget_bench.md
# budget_bench

Parametrised multi-channel successor to the single-channel request/response synthesis bench. Each channel receives an uncontrollable request and a controllable grant input, spends a bounded response budget, and must answer each request within a configurable deadline. A fixed-priority arbiter permits at most one response per cycle. Any missed deadline raises a sticky error that the model checker and synthesis flow treat as the bad-state output.

## Interface
- `N_CH`, default 2: number of request channels (≥1).
- `CNT_W`, default 3: width of each per-channel budget counter.
- `LIMIT`, default 3: responses allowed per channel per budget window. Must satisfy 1 ≤ LIMIT ≤ 2^CNT_W−1.
- `DEADLINE`, default 1: number of consecutive unserved clock edges before a channel fails (≥1).
- `REFILL_PERIOD`, default 16: budget refill interval in cycles. Used only with `BUDGET_REFILL_EN`.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i` in N_CH: uncontrollable request, one bit per channel.
- `controllable_i` in N_CH: controllable grant permission, one bit per channel.
- `error` out 1: registered OR of `err_ch`.
- `err_ch` out N_CH: registered per-channel fail flag.
- `grant` out N_CH: registered, one-hot-or-zero record of the response issued at the last edge.
- `_rt_get` out 1: combinational `|i`.

## Operation
- Per-channel state is one of CH_IDLE, CH_WAIT or CH_FAIL.
- Each channel keeps a wait counter of width $clog2(DEADLINE+1) and a budget counter `cnt` of width CNT_W.
- Combinational terms per channel k:
  - `req_k = i[k] | (state==CH_WAIT)`
  - `elig_k = req_k & controllable_i[k] & (cnt_k < LIMIT) & (state!=CH_FAIL)`
  - `resp_k = elig_k & ~|elig[k-1:0]` (lowest index wins)
- At each posedge, in priority order:
  - **resp_k:** `cnt_k` increments, wait counter clears, state goes to CH_IDLE. `cnt` never exceeds LIMIT and never wraps.
  - **else req_k, not CH_FAIL:** wait counter increments. When it reaches DEADLINE, state goes to CH_FAIL; otherwise state goes to CH_WAIT.
  - **else:** state holds.
- CH_FAIL is absorbing until reset. Counters are frozen and the channel is never eligible.
- A new `i[k]` while in CH_WAIT is the same request: no queueing and no wait restart.
- `grant[k] <= resp_k`. `err_ch[k] <= (next_state==CH_FAIL)`.
- Reset values: every state is CH_IDLE, all counters 0, `grant`=0, `err_ch`=0, `error`=0.

## Timing
- `_rt_get` has zero latency. Every other output has one cycle of latency from the deciding edge.
- With DEADLINE=1, a request left unserved at an edge raises `err_ch` in the following cycle, matching the single-channel semantics except that the error is now sticky.
- Reset is asynchronous: asserting `rst_n` low at any time, including mid-CH_WAIT or in CH_FAIL, clears all outputs immediately without a clock edge. Deassertion is synchronised externally.
- When two channels are eligible in the same cycle, the lower index is served. The other channel's wait counter advances.

## Configuration
- Macro: `BUDGET_REFILL_EN`.
- **Defined:** a free-running refill counter of width $clog2(REFILL_PERIOD) counts 0..REFILL_PERIOD−1. On the edge where it wraps, every non-failed channel's `cnt` clears to 0. If a response occurs on that same edge, the refill applies first and the response then counts, so `cnt`=1. CH_FAIL channels are untouched.
- **Undefined:** no refill counter is built and REFILL_PERIOD is ignored. After LIMIT responses a channel's budget is permanently exhausted, and its next request leads to failure after DEADLINE edges.

## Structure
- Package `budget_bench_pkg` holds:
  - typedef `ch_state_t` {CH_IDLE, CH_WAIT, CH_FAIL}
  - width helper constants for the wait and refill counters
- Sub-module `budget_bench_ch`, one instance per channel, owns the state, wait counter and budget counter. It takes `resp_k`, `req_k` and the refill strobe, and exports `elig_k` and the fail flag.
- The top level holds the priority arbiter, the refill counter, the `grant`/`error` registers and `_rt_get`.

## Test plan
- **Budget exhaustion, no refill:** defaults; `i`=01 and `controllable_i`=01 held → `grant`=01 on 3 consecutive cycles. On the 4th edge ch0 fails, so `err_ch`=01 and `error`=1 one cycle later.
- **Contention:** `i`=11 and `controllable_i`=11 for one cycle, then `i`=00 → `grant`=01.
  - DEADLINE=1: `err_ch`=10.
  - DEADLINE=2: `grant`=10 next cycle and `error` stays 0.
- **Denied grant:** `i[0]` pulsed for one cycle with `controllable_i`=00, DEADLINE=3 → CH_WAIT persists after `i` drops. `err_ch`=01 after the 3rd edge and remains 1 with `i`=00.
- **Asynchronous reset:** drive into CH_FAIL, then pull `rst_n` low between edges → `error`, `err_ch` and `grant` read 0 before the next posedge. After release, a fresh request is served normally.
- **Refill (`BUDGET_REFILL_EN`):** exhaust ch0 with 3 grants, keep requesting with DEADLINE=16, refill at cycle 16 → `grant`=01 on that edge and `error` stays 0. Without the macro → `err_ch`=01.
